// File: rtl/tt_sweep_pkg.sv
// Shared types and default sizing for the truth-table sweep controller.
// The settle-counter width is derived from SETTLE so the counter always holds SETTLE itself.
package tt_sweep_pkg;

    localparam int IN_W_DEF   = 8;
    localparam int OUT_W_DEF  = 5;
    localparam int SETTLE_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int settle_cw(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

    localparam int SETTLE_CW_DEF = settle_cw(SETTLE_DEF);

endpackage

// File: rtl/tt_check_accum.sv
// Compares both implementation outputs against the ROM word and accumulates
// sticky flags, the failing-vector count and the lowest failing vector.
module tt_check_accum
    import tt_sweep_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_x,
    input  logic [OUT_W-1:0] i_y_ddnf,
    input  logic [OUT_W-1:0] i_y_dknf,
    input  logic [OUT_W-1:0] i_rom_data,
    output logic             o_mis,
    output logic             o_err_ddnf,
    output logic             o_err_dknf,
    output logic [IN_W:0]    o_err_count,
    output logic             o_first_err_valid,
    output logic [IN_W-1:0]  o_first_err_addr
);

    logic w_mis_ddnf;
    logic w_mis_dknf;

    assign w_mis_ddnf = (i_y_ddnf != i_rom_data);
    assign w_mis_dknf = (i_y_dknf != i_rom_data);
    assign o_mis      = w_mis_ddnf | w_mis_dknf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err_ddnf        <= 1'b0;
            o_err_dknf        <= 1'b0;
            o_err_count       <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
        end else if (i_clr) begin
            o_err_ddnf        <= 1'b0;
            o_err_dknf        <= 1'b0;
            o_err_count       <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
        end else if (i_en) begin
            o_err_ddnf <= o_err_ddnf | w_mis_ddnf;
            o_err_dknf <= o_err_dknf | w_mis_dknf;
            if (o_mis) begin
                o_err_count <= o_err_count + 1'b1;
                // Vectors are swept in ascending order, so the first capture is the lowest failure.
                if (!o_first_err_valid) begin
                    o_first_err_valid <= 1'b1;
                    o_first_err_addr  <= i_x;
                end
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table self-test sequencer: walks every input vector, waits for
// the DUTs and ROM to settle, then checks both implementations against the ROM word.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_err,
    output logic [IN_W-1:0]  i_x,
    input  logic [OUT_W-1:0] o_y_ddnf,
    input  logic [OUT_W-1:0] o_y_dknf,
    output logic [IN_W-1:0]  rom_addr,
    input  logic [OUT_W-1:0] rom_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic             err_ddnf,
    output logic             err_dknf,
    output logic             first_err_valid,
    output logic [IN_W-1:0]  first_err_addr
);

    localparam int CW = settle_cw(SETTLE);

    state_t          r_state;
    state_t          w_next;
    logic [IN_W-1:0] r_x;
    logic [CW-1:0]   r_cnt;
    logic            r_stop;
    logic            r_pass;
    logic            r_busy;
    logic            r_done;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_start_acc;
    logic            w_check;
    logic            w_last;
    logic            w_mis;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_check     = (r_state == CHECK);
    assign w_last      = (r_x == {IN_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = APPLY;
            APPLY:   w_next = WAIT;
            WAIT:    if (r_cnt == CW'(1)) w_next = CHECK;
            CHECK:   w_next = (w_last || (w_mis && r_stop)) ? DONE : APPLY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_next != IDLE);
        w_done_nxt = (w_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_cnt  <= '0;
            r_stop <= 1'b0;
            r_pass <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_start_acc) begin
                r_x    <= '0;
                r_stop <= stop_on_err;
                r_pass <= 1'b0;
            end
            if (r_state == APPLY) r_cnt <= CW'(SETTLE);
            if (r_state == WAIT)  r_cnt <= r_cnt - 1'b1;
            if (w_check) begin
                if (w_next == APPLY) begin
                    r_x <= r_x + 1'b1;
                end else begin
                    // The accumulator updates on this same edge, so fold in the final verdict here.
                    r_pass <= (err_count == '0) && !w_mis;
                end
            end
        end
    end

    tt_check_accum #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_accum (
        .clk               (clk),
        .rst               (rst),
        .i_clr             (w_start_acc),
        .i_en              (w_check),
        .i_x               (r_x),
        .i_y_ddnf          (o_y_ddnf),
        .i_y_dknf          (o_y_dknf),
        .i_rom_data        (rom_data),
        .o_mis             (w_mis),
        .o_err_ddnf        (err_ddnf),
        .o_err_dknf        (err_dknf),
        .o_err_count       (err_count),
        .o_first_err_valid (first_err_valid),
        .o_first_err_addr  (first_err_addr)
    );

    assign i_x      = r_x;
    assign rom_addr = r_x;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: behavioural DUT/ROM models with injectable faults,
// a table of full-sweep scenarios, and hand-written reset/re-launch/SETTLE=3 sequences.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop_on_err = 1'b0;
    logic [7:0] i_x, rom_addr, first_err_addr;
    logic [4:0] o_y_ddnf, o_y_dknf, rom_data;
    logic       busy, done, pass, err_ddnf, err_dknf, first_err_valid;
    logic [8:0] err_count;

    logic       start3 = 1'b0;
    logic [7:0] i_x3, rom_addr3, first_err_addr3;
    logic [4:0] o_y_ddnf3, o_y_dknf3, rom_data3;
    logic       busy3, done3, pass3, err_ddnf3, err_dknf3, first_err_valid3;
    logic [8:0] err_count3;

    bit fault_ddnf = 1'b0;
    bit fault_rom  = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_f(input logic [7:0] x);
        logic [7:0] t;
        t = (x * 8'd7) ^ (x >> 3);
        return t[4:0];
    endfunction

    always_comb begin
        o_y_ddnf = ref_f(i_x) ^ ((fault_ddnf && (i_x == 8'h10 || i_x == 8'hFF)) ? 5'b00100 : 5'b00000);
        o_y_dknf = ref_f(i_x);
        o_y_ddnf3 = ref_f(i_x3);
        o_y_dknf3 = ref_f(i_x3);
    end

    always @(posedge clk) begin
        rom_data  <= ref_f(rom_addr) ^ ((fault_rom && rom_addr == 8'h80) ? 5'h01 : 5'h00);
        rom_data3 <= ref_f(rom_addr3);
    end

    tt_sweep_ctrl #(.IN_W(8), .OUT_W(5), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
        .i_x(i_x), .o_y_ddnf(o_y_ddnf), .o_y_dknf(o_y_dknf),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_ddnf(err_ddnf), .err_dknf(err_dknf),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr)
    );

    tt_sweep_ctrl #(.IN_W(8), .OUT_W(5), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop_on_err(1'b0),
        .i_x(i_x3), .o_y_ddnf(o_y_ddnf3), .o_y_dknf(o_y_dknf3),
        .rom_addr(rom_addr3), .rom_data(rom_data3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .err_ddnf(err_ddnf3), .err_dknf(err_dknf3),
        .first_err_valid(first_err_valid3), .first_err_addr(first_err_addr3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Launches one sweep and counts busy cycles and done pulses until busy falls.
    task automatic run_sweep(input bit stop, input bit repulse,
                             output int cyc, output int ndone, output int first_x);
        @(negedge clk);
        stop_on_err = stop;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        ndone = 0;
        first_x = int'(i_x);
        for (int k = 0; k < 4000; k++) begin
            if (!busy) break;
            cyc++;
            if (done) ndone++;
            start = (repulse && (cyc == 100 || cyc == 500)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    typedef struct {
        bit f_ddnf; bit f_rom; bit stop; bit repulse;
        int exp_cyc; int exp_ec; bit exp_dd; bit exp_dk;
        bit exp_fv; int exp_fa; bit exp_pass; int exp_x;
    } vec_t;

    vec_t tv[7];

    initial begin
        int cyc, ndone, fx, k;
        string tag;

        tv[0] = '{0, 0, 0, 0, 769, 0, 0, 0, 0, 8'h00, 1, 8'hFF};
        tv[1] = '{1, 0, 0, 0, 769, 2, 1, 0, 1, 8'h10, 0, 8'hFF};
        tv[2] = '{1, 0, 1, 0,  52, 1, 1, 0, 1, 8'h10, 0, 8'h10};
        tv[3] = '{0, 1, 0, 0, 769, 1, 1, 1, 1, 8'h80, 0, 8'hFF};
        tv[4] = '{0, 1, 1, 0, 388, 1, 1, 1, 1, 8'h80, 0, 8'h80};
        tv[5] = '{0, 0, 1, 0, 769, 0, 0, 0, 0, 8'h00, 1, 8'hFF};
        tv[6] = '{1, 0, 0, 1, 769, 2, 1, 0, 1, 8'h10, 0, 8'hFF};

        #1 rst = 1'b1;
        #3;
        chk("reset_outputs", {7'd0, i_x, rom_addr, busy, done, pass, err_count, err_ddnf, err_dknf,
                              first_err_valid}, 32'd0);
        chk("reset_first_addr", {24'd0, first_err_addr}, 32'd0);
        chk("reset_dut3", {22'd0, i_x3, busy3, done3, err_count3}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fault_ddnf = tv[i].f_ddnf;
            fault_rom  = tv[i].f_rom;
            run_sweep(tv[i].stop, tv[i].repulse, cyc, ndone, fx);
            tag = $sformatf("v%0d", i);
            chk({tag, "_busy_cycles"}, cyc, tv[i].exp_cyc);
            chk({tag, "_done_pulses"}, ndone, 1);
            chk({tag, "_first_x"}, fx, 0);
            chk({tag, "_err_count"}, {23'd0, err_count}, tv[i].exp_ec);
            chk({tag, "_err_ddnf"}, {31'd0, err_ddnf}, {31'd0, tv[i].exp_dd});
            chk({tag, "_err_dknf"}, {31'd0, err_dknf}, {31'd0, tv[i].exp_dk});
            chk({tag, "_first_valid"}, {31'd0, first_err_valid}, {31'd0, tv[i].exp_fv});
            chk({tag, "_first_addr"}, {24'd0, first_err_addr}, tv[i].exp_fa);
            chk({tag, "_pass"}, {31'd0, pass}, {31'd0, tv[i].exp_pass});
            chk({tag, "_final_x"}, {24'd0, i_x}, tv[i].exp_x);
        end

        // Reset in the middle of a faulty sweep, at vector 0x40.
        fault_ddnf = 1'b1;
        fault_rom  = 1'b0;
        @(negedge clk);
        stop_on_err = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (i_x != 8'h40 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrst_reach_0x40", {24'd0, i_x}, 32'h40);
        chk("midrst_pre_err_count", {23'd0, err_count}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {7'd0, i_x, rom_addr, busy, done, pass, err_count, err_ddnf, err_dknf,
                               first_err_valid}, 32'd0);
        chk("midrst_first_addr", {24'd0, first_err_addr}, 32'd0);
        ndone = 0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("midrst_no_done_or_busy", ndone, 0);
        fault_ddnf = 1'b0;
        run_sweep(1'b0, 1'b0, cyc, ndone, fx);
        chk("postrst_first_x", fx, 0);
        chk("postrst_busy_cycles", cyc, 769);
        chk("postrst_pass", {31'd0, pass}, 32'd1);

        // start held across DONE->IDLE re-launches after one idle cycle.
        @(negedge clk);
        start = 1'b1;
        k = 0;
        @(posedge clk); #1;
        while (!done && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold_done_seen", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        chk("hold_idle_gap", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("hold_relaunch_busy", {31'd0, busy}, 32'd1);
        chk("hold_relaunch_x", {24'd0, i_x}, 32'd0);
        start = 1'b0;
        k = 0;
        while (busy && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold_second_pass", {31'd0, pass}, 32'd1);

        // SETTLE=3 instance: 256 * 5 + 1 busy cycles.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 0;
        ndone = 0;
        for (int j = 0; j < 4000; j++) begin
            if (!busy3) break;
            cyc++;
            if (done3) ndone++;
            @(posedge clk); #1;
        end
        chk("s3_busy_cycles", cyc, 1281);
        chk("s3_done_pulses", ndone, 1);
        chk("s3_pass", {31'd0, pass3}, 32'd1);
        chk("s3_err_count", {23'd0, err_count3}, 32'd0);
        chk("s3_flags", {29'd0, err_ddnf3, err_dknf3, first_err_valid3}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Hardware sequencer that exhaustively sweeps every input vector of a truth-table function, drives both the DDNF and DKNF implementations of that function, fetches the expected output from a synchronous table ROM, and accumulates mismatch results. It sits between a start/done control interface and the two combinational DUT instances plus the table ROM, replacing file-driven simulation checking with an on-chip self-test.

## Interface
- `IN_W`, 8, input vector width; the sweep covers 2^IN_W vectors.
- `OUT_W`, 5, output vector width of each implementation and of each ROM word.
- `SETTLE`, 1, wait cycles after a vector is applied; must be ≥1 so it also covers the ROM's 1-cycle read latency.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `stop_on_err` in 1: sampled at start; if 1, the sweep ends at the first mismatch.
- `i_x` out IN_W: vector driven to both DUTs.
- `o_y_ddnf` in OUT_W: DDNF implementation output.
- `o_y_dknf` in OUT_W: DKNF implementation output.
- `rom_addr` out IN_W: table ROM address; always equals `i_x`.
- `rom_data` in OUT_W: ROM word, valid 1 cycle after `rom_addr`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep ends.
- `pass` out 1: valid from `done` onward; 1 when `err_count` is 0.
- `err_count` out IN_W+1: number of vectors with any mismatch (range 0..2^IN_W).
- `err_ddnf`, `err_dknf` out 1 each: sticky per-implementation mismatch flags.
- `first_err_valid` out 1, `first_err_addr` out IN_W: lowest failing vector.

## Operation
- States: IDLE → APPLY → WAIT → CHECK → (APPLY | DONE) → IDLE.
- IDLE, `start`=1:
  - Clear `err_count`, both sticky flags, `first_err_*` and `pass`.
  - Latch `stop_on_err`, set `i_x`=0 and go to APPLY.
- APPLY: `i_x`/`rom_addr` are stable. Go to WAIT and load the settle counter with SETTLE.
- WAIT: decrement the counter; at 0 go to CHECK.
- CHECK:
  - Vector mismatch = (`o_y_ddnf`≠`rom_data`) OR (`o_y_dknf`≠`rom_data`).
  - Set each sticky flag from its own compare.
  - On a mismatch, `err_count`+1. If `first_err_valid`=0, capture `i_x` into `first_err_addr` and set `first_err_valid`.
  - Go to DONE if `i_x`=2^IN_W−1, or if there is a mismatch and `stop_on_err` was latched. Otherwise `i_x`+1 and go to APPLY.
- DONE:
  - `done`=1 for one cycle and `pass` = (`err_count`==0), including the increment from the final CHECK.
  - Go to IDLE. Results hold until the next `start`.
- `start` outside IDLE is ignored. `start` held high across DONE→IDLE re-launches a sweep on the next cycle.
- `i_x` increments without wrap. The terminal vector is detected explicitly, so `i_x` never rolls to 0 inside a sweep.
- `err_count` is IN_W+1 bits wide, so it holds 2^IN_W exactly and needs no saturation.

## Timing
- Reset values: state=IDLE; `i_x`, `rom_addr`, `busy`, `done`, `pass`, `err_count`, `err_ddnf`, `err_dknf`, `first_err_valid`, `first_err_addr` are all 0.
- Reset mid-sweep aborts immediately to these values. `done` is not pulsed.
- Per-vector cost is 2+SETTLE cycles. A full sweep takes 2^IN_W·(2+SETTLE) cycles from the first APPLY, plus 1 DONE cycle. With defaults: 768 + 1.
- `busy`=1 from the cycle after `start` is accepted through the DONE cycle inclusive.
- All outputs are registered. Compare inputs are sampled only in CHECK.

## Structure
- Package `tt_sweep_pkg`:
  - State enum (IDLE, APPLY, WAIT, CHECK, DONE).
  - Default `IN_W`/`OUT_W`/`SETTLE` constants.
  - Settle-counter width, defined as clog2(SETTLE+1).
- One sub-module, `tt_check_accum`. It contains the two OUT_W compares, the sticky flags, the error counter and the first-error capture. It is enabled by the CHECK strobe and cleared by the start strobe.
- The top level holds the FSM, the vector counter and the settle counter.

## Test plan
- Correct DUTs and matching ROM, default parameters, `start` pulse: `done` after 769 cycles; `pass`=1, `err_count`=0, no flags set.
- DDNF output bit 2 forced wrong at vectors 0x10 and 0xFF: `err_count`=2, `err_ddnf`=1, `err_dknf`=0, `first_err_addr`=0x10, `pass`=0.
- Same fault with `stop_on_err`=1: `done` after the CHECK of 0x10, i.e. 17·3+1=52 cycles. `err_count`=1, `i_x`=0x10.
- ROM word corrupted at 0x80 while both DUTs are correct: both sticky flags set, `err_count`=1, `first_err_addr`=0x80.
- `rst` asserted at vector 0x40: all outputs are 0 immediately and there is no `done`. A new `start` sweeps from 0.
- `start` repulsed while `busy`: no effect on `i_x` progression or on total cycle count. `SETTLE`=3 variant: sweep takes 1280+1 cycles.
